// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier.
//   state_e    : controller states (idle, multiply-accumulate, completion pulse)
//   elem_off   : bit offset of element [i][j] in a row-major bus, [0][0] in the MSBs
//   acc_width  : accumulator width that can hold an N-term sum of DW x DW products
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  function automatic int unsigned elem_off(input int unsigned i, input int unsigned j,
                                           input int unsigned n, input int unsigned w);
    return (n * n - 1 - (i * n + j)) * w;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate lane with output reduction.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear the accumulator (new job)
//   en_i         : add a_i * b_i this cycle
//   last_i       : this is the final term of a dot product; accumulator restarts at 0
//   a_i, b_i     : unsigned operands
//   sat_i        : 1 = saturate to all-ones on overflow of OW bits, 0 = wrap
//   res_o        : reduced value of (acc + a_i * b_i), valid in the last_i cycle
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          last_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          sat_i,
  output logic [OW-1:0] res_o
);

  localparam int unsigned AW    = acc_width(DW, N);
  localparam int unsigned WideW = (AW > OW) ? AW : OW;

  logic [2*DW-1:0]  prod;
  logic [AW-1:0]    acc_q, acc_d, sum;
  logic [WideW-1:0] sum_w, sat_max;

  always_comb begin
    prod    = (2 * DW)'(a_i) * (2 * DW)'(b_i);
    sum     = acc_q + AW'(prod);
    sum_w   = WideW'(sum);
    sat_max = WideW'({OW{1'b1}});
    // Result is taken from the running sum including the current term, so the final
    // element is available in the same cycle it is accumulated.
    if (sat_i && (sum_w > sat_max)) begin
      res_o = '1;
    end else begin
      res_o = sum_w[OW-1:0];
    end

    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential unsigned N x N matrix multiplier, one MAC per clock.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a multiply (accepted only when idle)
//   mode_sat          : 0 = wrap, 1 = saturate results to OW bits (captured with start)
//   a_flat, b_flat    : operand matrices, row-major, [0][0] in the MSBs (captured with start)
//   busy              : computation in progress
//   done              : one-cycle pulse, res_flat holds the new result in that cycle
//   res_flat          : result matrix, same packing, held between completions
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_sat,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic              busy,
  output logic              done,
  output logic [N*N*OW-1:0] res_flat
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] IdxLast = IW'(N - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic [N*N*DW-1:0] a_q, a_d, b_q, b_d;
  logic              sat_q, sat_d;
  logic [N*N*OW-1:0] shadow_q, shadow_d, res_q, res_d;

  logic              mac_clr, mac_en, mac_last;
  logic [DW-1:0]     a_elem, b_elem;
  logic [OW-1:0]     mac_res;

  always_comb begin
    a_elem = a_q[elem_off(32'(i_q), 32'(k_q), N, DW) +: DW];
    b_elem = b_q[elem_off(32'(k_q), 32'(j_q), N, DW) +: DW];
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    sat_d    = sat_q;
    shadow_d = shadow_q;
    res_d    = res_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_last = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_flat;
          b_d     = b_flat;
          sat_d   = mode_sat;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        mac_en = 1'b1;
        if (k_q == IdxLast) begin
          mac_last = 1'b1;
          shadow_d[elem_off(32'(i_q), 32'(j_q), N, OW) +: OW] = mac_res;
          k_d = '0;
          if (j_q == IdxLast) begin
            j_d = '0;
            if (i_q == IdxLast) begin
              i_d     = '0;
              state_d = StDone;
              // Load the output on entry to DONE so it is visible during the done pulse.
              res_d   = shadow_d;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sat_q    <= 1'b0;
      shadow_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sat_q    <= sat_d;
      shadow_q <= shadow_d;
      res_q    <= res_d;
    end
  end

  matmul_mac #(
    .N  (N),
    .DW (DW),
    .OW (OW)
  ) u_mac (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .last_i (mac_last),
    .a_i    (a_elem),
    .b_i    (b_elem),
    .sat_i  (sat_q),
    .res_o  (mac_res)
  );

  assign busy     = (state_q == StCalc);
  assign done     = (state_q == StDone);
  assign res_flat = res_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed self-checking bench for matmul_seq: a 2x2 8-bit instance and a 3x3 16-bit-output
// instance sharing clock and reset.
module tb_matmul_seq;

  logic         clk;
  logic         rst;
  logic         start2, sat2, busy2, done2;
  logic [31:0]  a2, b2, res2;
  logic         start3, sat3, busy3, done3;
  logic [71:0]  a3, b3;
  logic [143:0] res3;

  int n_cmp;
  int n_err;

  matmul_seq #(.N(2), .DW(8), .OW(8)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .mode_sat (sat2),
    .a_flat   (a2),
    .b_flat   (b2),
    .busy     (busy2),
    .done     (done2),
    .res_flat (res2)
  );

  matmul_seq #(.N(3), .DW(8), .OW(16)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .start    (start3),
    .mode_sat (sat3),
    .a_flat   (a3),
    .b_flat   (b3),
    .busy     (busy3),
    .done     (done3),
    .res_flat (res3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Runs one 2x2 job: accept edge, then observes cycles 1..14. Optionally re-pulses start
  // with other operands in cycle inj_c to confirm it is ignored.
  task automatic go2(input logic [31:0] a, input logic [31:0] b, input logic sat,
                     input int inj_c, input logic [31:0] inj_a,
                     output int done_at, output int ndone, output int busy_bad);
    done_at  = -1;
    ndone    = 0;
    busy_bad = 0;
    a2 = a; b2 = b; sat2 = sat; start2 = 1'b1;
    cycle();
    start2 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == inj_c) begin
        start2 = 1'b1;
        a2     = inj_a;
        sat2   = ~sat;
      end else begin
        start2 = 1'b0;
      end
      if (done2) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if ((c <= 8) != busy2) busy_bad++;
      cycle();
    end
    start2 = 1'b0;
  endtask

  initial begin
    int dat, nd, bb, t1, t2;
    logic [31:0] r1, r2;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start2 = 1'b0; sat2 = 1'b0; a2 = '0; b2 = '0;
    start3 = 1'b0; sat3 = 1'b0; a3 = '0; b3 = '0;
    cycle();
    cycle();
    check("rst_busy2", 144'(busy2), 144'd0);
    check("rst_done2", 144'(done2), 144'd0);
    check("rst_res2", 144'(res2), 144'd0);
    check("rst_busy3", 144'(busy3), 144'd0);
    check("rst_res3", res3, 144'd0);
    rst = 1'b0;
    cycle();

    // Basic wrap case
    go2(32'h01020304, 32'h05060708, 1'b0, 0, 32'h0, dat, nd, bb);
    check("basic_done_at", 144'(dat), 144'd9);
    check("basic_ndone", 144'(nd), 144'd1);
    check("basic_busy", 144'(bb), 144'd0);
    check("basic_res", 144'(res2), 144'h13162B32);

    // All-ones operands, wrap then saturate
    go2(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 32'h0, dat, nd, bb);
    check("ff_wrap_done_at", 144'(dat), 144'd9);
    check("ff_wrap_res", 144'(res2), 144'h02020202);
    go2(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 32'h0, dat, nd, bb);
    check("ff_sat_res", 144'(res2), 144'hFFFFFFFF);

    // Start while busy is ignored
    go2(32'h01020304, 32'h05060708, 1'b0, 4, 32'hFFFFFFFF, dat, nd, bb);
    check("ign_done_at", 144'(dat), 144'd9);
    check("ign_ndone", 144'(nd), 144'd1);
    check("ign_busy", 144'(bb), 144'd0);
    check("ign_res", 144'(res2), 144'h13162B32);

    // Reset mid-calculation
    a2 = 32'hFFFFFFFF; b2 = 32'hFFFFFFFF; sat2 = 1'b0; start2 = 1'b1;
    cycle();
    start2 = 1'b0;
    for (int c = 1; c < 5; c++) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_busy", 144'(busy2), 144'd0);
    check("midrst_done", 144'(done2), 144'd0);
    check("midrst_res", 144'(res2), 144'd0);
    rst = 1'b0;
    go2(32'h01000001, 32'h05060708, 1'b0, 0, 32'h0, dat, nd, bb);
    check("postrst_done_at", 144'(dat), 144'd9);
    check("postrst_res", 144'(res2), 144'h05060708);

    // Back-to-back with start held high; operands re-captured at each accept
    t1 = -1; t2 = -1; nd = 0; r1 = '0; r2 = '0;
    a2 = 32'h01020304; b2 = 32'h05060708; sat2 = 1'b0; start2 = 1'b1;
    cycle();
    a2 = 32'h02000002;
    for (int c = 1; c <= 24; c++) begin
      if (done2) begin
        nd++;
        if (nd == 1) begin
          t1 = c; r1 = res2;
        end else if (nd == 2) begin
          t2 = c; r2 = res2; start2 = 1'b0;
        end
      end
      cycle();
    end
    start2 = 1'b0;
    check("b2b_ndone", 144'(nd), 144'd2);
    check("b2b_t1", 144'(t1), 144'd9);
    check("b2b_spacing", 144'(t2 - t1), 144'd10);
    check("b2b_res1", 144'(r1), 144'h13162B32);
    check("b2b_res2", 144'(r2), 144'h0A0C0E10);

    // 3x3, identity times 1..9, widened to 16 bits
    t1 = -1; nd = 0; bb = 0;
    a3 = 72'h010000000100000001;
    b3 = 72'h010203040506070809;
    sat3 = 1'b0; start3 = 1'b1;
    cycle();
    start3 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (done3) begin
        nd++;
        if (t1 < 0) t1 = c;
      end
      if ((c <= 27) != busy3) bb++;
      cycle();
    end
    check("n3_done_at", 144'(t1), 144'd28);
    check("n3_ndone", 144'(nd), 144'd1);
    check("n3_busy", 144'(bb), 144'd0);
    check("n3_res", res3, 144'h000100020003000400050006000700080009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
